// File: rtl/ufifo_dmp_if.sv
// Bus bundle for the ufifo_dmp queue: push/pop handshake, level flags and the dump port.
// The producer/consumer side uses master, the FIFO itself uses slave.
interface ufifo_dmp_if #(
  parameter int DW     = 8,
  parameter int LGFLEN = 5
);
  logic              i_clr;
  logic              i_wr;
  logic [DW-1:0]     i_data;
  logic              i_rd;
  logic [DW-1:0]     o_data;
  logic              o_empty_n;
  logic              o_full;
  logic              o_afull;
  logic              o_aempty;
  logic [LGFLEN:0]   o_fill;
  logic              o_ovf;
  logic              o_udf;
  logic [LGFLEN-1:0] i_dmp_pos;
  logic [DW-1:0]     o_dmp_data;
  logic              o_dmp_valid;

  modport master (
    output i_clr, i_wr, i_data, i_rd, i_dmp_pos,
    input  o_data, o_empty_n, o_full, o_afull, o_aempty, o_fill,
           o_ovf, o_udf, o_dmp_data, o_dmp_valid
  );

  modport slave (
    input  i_clr, i_wr, i_data, i_rd, i_dmp_pos,
    output o_data, o_empty_n, o_full, o_afull, o_aempty, o_fill,
           o_ovf, o_udf, o_dmp_data, o_dmp_valid
  );
endinterface

// File: rtl/ufifo_dmp.sv
// Synchronous FIFO with fill-level flags, sticky overflow/underflow and a registered
// random-access dump port indexed from the head of the queue.
module ufifo_dmp #(
  parameter int DW        = 8,
  parameter int LGFLEN    = 5,
  parameter int AF_THRESH = 28,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  ufifo_dmp_if.slave   bus
);
  localparam int              DEPTH   = 1 << LGFLEN;
  localparam logic [LGFLEN:0] DEPTH_V = (LGFLEN+1)'(DEPTH);
  localparam logic [LGFLEN:0] AF_V    = (LGFLEN+1)'(AF_THRESH);
  localparam logic [LGFLEN:0] AE_V    = (LGFLEN+1)'(AE_THRESH);

  logic [DW-1:0]     mem [DEPTH];

  logic [LGFLEN:0]   wr_ptr, rd_ptr;
  logic [LGFLEN:0]   wr_ptr_n, rd_ptr_n, fill_n;
  logic [LGFLEN:0]   fill_r;
  logic              empty_n_r, full_r, afull_r, aempty_r;
  logic              ovf_r, udf_r;
  logic              pop_ok, push_ok;
  logic [LGFLEN-1:0] wr_idx, rd_idx, dmp_idx;
  logic              dmp_hit;
  logic [DW-1:0]     dmp_data_r;
  logic              dmp_valid_r;

  // A pop frees the slot in the same cycle, so a full queue still takes a push.
  always_comb begin
    pop_ok   = bus.i_rd && empty_n_r;
    push_ok  = bus.i_wr && (!full_r || pop_ok);
    wr_ptr_n = wr_ptr + (LGFLEN+1)'(push_ok);
    rd_ptr_n = rd_ptr + (LGFLEN+1)'(pop_ok);
    fill_n   = wr_ptr_n - rd_ptr_n;
    wr_idx   = wr_ptr[LGFLEN-1:0];
    rd_idx   = rd_ptr[LGFLEN-1:0];
    dmp_idx  = rd_idx + bus.i_dmp_pos;
    dmp_hit  = {1'b0, bus.i_dmp_pos} < fill_r;
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !bus.i_clr)
      mem[wr_idx] <= bus.i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill_r    <= '0;
      empty_n_r <= 1'b0;
      full_r    <= 1'b0;
      afull_r   <= 1'b0;
      aempty_r  <= 1'b1;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
    end else if (bus.i_clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill_r    <= '0;
      empty_n_r <= 1'b0;
      full_r    <= 1'b0;
      afull_r   <= 1'b0;
      aempty_r  <= 1'b1;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      fill_r    <= fill_n;
      empty_n_r <= (fill_n != '0);
      full_r    <= (fill_n == DEPTH_V);
      afull_r   <= (fill_n >= AF_V);
      aempty_r  <= (fill_n <= AE_V);
      ovf_r     <= ovf_r | (bus.i_wr && !push_ok);
      udf_r     <= udf_r | (bus.i_rd && !pop_ok);
    end
  end

  // Dump reads use the pre-edge head and fill; invalid slots read back as zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dmp_data_r  <= '0;
      dmp_valid_r <= 1'b0;
    end else if (bus.i_clr) begin
      dmp_data_r  <= '0;
      dmp_valid_r <= 1'b0;
    end else begin
      dmp_valid_r <= dmp_hit;
      dmp_data_r  <= dmp_hit ? mem[dmp_idx] : '0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.o_data = empty_n_r ? mem[rd_idx] : '0;
    end else begin : g_reg
      logic [DW-1:0] data_r;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
          data_r <= '0;
        else if (bus.i_clr)
          data_r <= '0;
        else if (pop_ok)
          data_r <= mem[rd_idx];
      end
      assign bus.o_data = data_r;
    end
  endgenerate

  assign bus.o_empty_n   = empty_n_r;
  assign bus.o_full      = full_r;
  assign bus.o_afull     = afull_r;
  assign bus.o_aempty    = aempty_r;
  assign bus.o_fill      = fill_r;
  assign bus.o_ovf       = ovf_r;
  assign bus.o_udf       = udf_r;
  assign bus.o_dmp_data  = dmp_data_r;
  assign bus.o_dmp_valid = dmp_valid_r;
endmodule

// File: tb/tb_ufifo_dmp.sv
// Directed bench for ufifo_dmp: one FWFT instance and one registered-read instance.
module tb_ufifo_dmp;
  logic i_clk = 1'b0;
  logic i_rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 i_clk = ~i_clk;

  ufifo_dmp_if #(.DW(8), .LGFLEN(5)) fa ();
  ufifo_dmp_if #(.DW(8), .LGFLEN(5)) fb ();

  ufifo_dmp #(.DW(8), .LGFLEN(5), .AF_THRESH(28), .AE_THRESH(2), .FWFT(1'b1)) u_a (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (fa)
  );

  ufifo_dmp #(.DW(8), .LGFLEN(5), .AF_THRESH(28), .AE_THRESH(2), .FWFT(1'b0)) u_b (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (fb)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    fa.i_clr = 1'b0; fa.i_wr = 1'b0; fa.i_rd = 1'b0; fa.i_data = '0; fa.i_dmp_pos = '0;
    fb.i_clr = 1'b0; fb.i_wr = 1'b0; fb.i_rd = 1'b0; fb.i_data = '0; fb.i_dmp_pos = '0;
  endtask

  task automatic clr_a();
    fa.i_clr = 1'b1;
    tick();
    fa.i_clr = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    idle();
    repeat (2) tick();
    n_tests++;
    if ({fa.o_empty_n, fa.o_full, fa.o_afull, fa.o_aempty, fa.o_ovf, fa.o_udf, fa.o_dmp_valid} !== 7'b0001000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0001000",
        {fa.o_empty_n, fa.o_full, fa.o_afull, fa.o_aempty, fa.o_ovf, fa.o_udf, fa.o_dmp_valid});
    end
    n_tests++;
    if (fa.o_fill !== 6'd0 || fa.o_data !== 8'd0 || fa.o_dmp_data !== 8'd0) begin
      n_fail++; $display("FAIL reset_vals got fill=%0d data=%h dmp=%h want 0 0 0", fa.o_fill, fa.o_data, fa.o_dmp_data);
    end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 8; i++) begin
      fa.i_wr = 1'b1; fa.i_data = 8'(i);
      tick();
    end
    fa.i_wr = 1'b0;
    n_tests++;
    if (fa.o_fill !== 6'd8) begin
      n_fail++; $display("FAIL pp_fill8 got %0d want 8", fa.o_fill);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (fa.o_data !== 8'(k)) begin
        n_fail++; $display("FAIL pp_head%0d got %h want %h", k, fa.o_data, 8'(k));
      end
      fa.i_rd = 1'b1;
      tick();
    end
    fa.i_rd = 1'b0;
    n_tests++;
    if (fa.o_data !== 8'd4 || fa.o_fill !== 6'd4 || fa.o_aempty !== 1'b0) begin
      n_fail++; $display("FAIL pp_after got data=%h fill=%0d aempty=%b want 04 4 0", fa.o_data, fa.o_fill, fa.o_aempty);
    end
    clr_a();
  endtask

  task automatic test_full();
    for (int c = 0; c < 32; c++) begin
      fa.i_wr = 1'b1; fa.i_data = 8'(c);
      tick();
      if (c >= 26) begin
        n_tests++;
        if (fa.o_afull !== (c + 1 >= 28) || fa.o_full !== (c == 31)) begin
          n_fail++; $display("FAIL full_flags fill=%0d got afull=%b full=%b want %b %b",
            c + 1, fa.o_afull, fa.o_full, (c + 1 >= 28), (c == 31));
        end
      end
    end
    fa.i_data = 8'hAA;
    tick();
    fa.i_wr = 1'b0;
    n_tests++;
    if (fa.o_ovf !== 1'b1 || fa.o_fill !== 6'd32 || fa.o_data !== 8'd0) begin
      n_fail++; $display("FAIL full_drop got ovf=%b fill=%0d head=%h want 1 32 00", fa.o_ovf, fa.o_fill, fa.o_data);
    end
    fa.i_wr = 1'b1; fa.i_rd = 1'b1; fa.i_data = 8'h55;
    tick();
    fa.i_wr = 1'b0; fa.i_rd = 1'b0;
    n_tests++;
    if (fa.o_fill !== 6'd32 || fa.o_full !== 1'b1 || fa.o_data !== 8'd1) begin
      n_fail++; $display("FAIL full_pushpop got fill=%0d full=%b head=%h want 32 1 01", fa.o_fill, fa.o_full, fa.o_data);
    end
    for (int k = 0; k < 32; k++) begin
      n_tests++;
      if (fa.o_data !== ((k < 31) ? 8'(k + 1) : 8'h55)) begin
        n_fail++; $display("FAIL full_order%0d got %h want %h", k, fa.o_data, (k < 31) ? 8'(k + 1) : 8'h55);
      end
      fa.i_rd = 1'b1;
      tick();
    end
    fa.i_rd = 1'b0;
    n_tests++;
    if (fa.o_empty_n !== 1'b0 || fa.o_fill !== 6'd0 || fa.o_aempty !== 1'b1) begin
      n_fail++; $display("FAIL full_drained got empty_n=%b fill=%0d aempty=%b want 0 0 1", fa.o_empty_n, fa.o_fill, fa.o_aempty);
    end
    clr_a();
  endtask

  task automatic test_underflow();
    fa.i_rd = 1'b1;
    tick();
    fa.i_rd = 1'b0;
    n_tests++;
    if (fa.o_udf !== 1'b1 || fa.o_fill !== 6'd0) begin
      n_fail++; $display("FAIL udf_empty got udf=%b fill=%0d want 1 0", fa.o_udf, fa.o_fill);
    end
    clr_a();
    n_tests++;
    if (fa.o_udf !== 1'b0) begin
      n_fail++; $display("FAIL udf_clr got %b want 0", fa.o_udf);
    end
    fa.i_wr = 1'b1; fa.i_rd = 1'b1; fa.i_data = 8'h6B;
    tick();
    fa.i_wr = 1'b0; fa.i_rd = 1'b0;
    n_tests++;
    if (fa.o_fill !== 6'd1 || fa.o_udf !== 1'b1 || fa.o_empty_n !== 1'b1 || fa.o_data !== 8'h6B) begin
      n_fail++; $display("FAIL udf_pushpop got fill=%0d udf=%b empty_n=%b data=%h want 1 1 1 6b",
        fa.o_fill, fa.o_udf, fa.o_empty_n, fa.o_data);
    end
    clr_a();
  endtask

  task automatic test_wrap_dump();
    for (int c = 0; c < 40; c++) begin
      fa.i_wr = 1'b1; fa.i_data = 8'(c & 7); fa.i_rd = (c >= 3);
      tick();
    end
    fa.i_wr = 1'b0; fa.i_rd = 1'b0;
    n_tests++;
    if (fa.o_fill !== 6'd3 || fa.o_data !== 8'd5) begin
      n_fail++; $display("FAIL wrap_state got fill=%0d head=%h want 3 05", fa.o_fill, fa.o_data);
    end
    for (int p = 0; p < 4; p++) begin
      fa.i_dmp_pos = 5'(p);
      tick();
      n_tests++;
      if (fa.o_dmp_valid !== (p < 3) || fa.o_dmp_data !== ((p < 3) ? 8'(5 + p) : 8'd0)) begin
        n_fail++; $display("FAIL dump_pos%0d got valid=%b data=%h want %b %h",
          p, fa.o_dmp_valid, fa.o_dmp_data, (p < 3), (p < 3) ? 8'(5 + p) : 8'd0);
      end
    end
    fa.i_dmp_pos = '0;
    clr_a();
  endtask

  task automatic test_regread();
    fb.i_wr = 1'b1; fb.i_data = 8'h11;
    tick();
    fb.i_data = 8'h22;
    tick();
    fb.i_wr = 1'b0;
    n_tests++;
    if (fb.o_data !== 8'h00 || fb.o_fill !== 6'd2) begin
      n_fail++; $display("FAIL rr_hold got data=%h fill=%0d want 00 2", fb.o_data, fb.o_fill);
    end
    fb.i_rd = 1'b1;
    tick();
    n_tests++;
    if (fb.o_data !== 8'h11) begin
      n_fail++; $display("FAIL rr_pop1 got %h want 11", fb.o_data);
    end
    tick();
    n_tests++;
    if (fb.o_data !== 8'h22 || fb.o_empty_n !== 1'b0) begin
      n_fail++; $display("FAIL rr_pop2 got data=%h empty_n=%b want 22 0", fb.o_data, fb.o_empty_n);
    end
    tick();
    fb.i_rd = 1'b0;
    n_tests++;
    if (fb.o_data !== 8'h22 || fb.o_udf !== 1'b1) begin
      n_fail++; $display("FAIL rr_empty got data=%h udf=%b want 22 1", fb.o_data, fb.o_udf);
    end
  endtask

  task automatic test_reset_clear();
    for (int c = 0; c < 33; c++) begin
      fa.i_wr = 1'b1; fa.i_data = 8'(c);
      tick();
    end
    fa.i_wr = 1'b0; fa.i_rd = 1'b1;
    repeat (22) tick();
    fa.i_rd = 1'b0;
    n_tests++;
    if (fa.o_fill !== 6'd10 || fa.o_ovf !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre got fill=%0d ovf=%b want 10 1", fa.o_fill, fa.o_ovf);
    end
    fa.i_wr = 1'b1; fa.i_data = 8'h99;
    #2;
    i_rst = 1'b1;
    #1;
    n_tests++;
    if (fa.o_fill !== 6'd0 || fa.o_empty_n !== 1'b0 || fa.o_ovf !== 1'b0 || fa.o_aempty !== 1'b1 ||
        fa.o_data !== 8'd0 || fa.o_full !== 1'b0) begin
      n_fail++; $display("FAIL rst_async got fill=%0d empty_n=%b ovf=%b aempty=%b data=%h full=%b want 0 0 0 1 00 0",
        fa.o_fill, fa.o_empty_n, fa.o_ovf, fa.o_aempty, fa.o_data, fa.o_full);
    end
    fa.i_wr = 1'b0;
    #1;
    i_rst = 1'b0;
    tick();
    fa.i_wr = 1'b1; fa.i_data = 8'h3C;
    tick();
    fa.i_wr = 1'b0; fa.i_dmp_pos = '0;
    tick();
    n_tests++;
    if (fa.o_fill !== 6'd1 || fa.o_data !== 8'h3C || fa.o_dmp_data !== 8'h3C || fa.o_dmp_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_first got fill=%0d data=%h dmp=%h dv=%b want 1 3c 3c 1",
        fa.o_fill, fa.o_data, fa.o_dmp_data, fa.o_dmp_valid);
    end
    clr_a();
    fa.i_rd = 1'b1;
    tick();
    fa.i_rd = 1'b0;
    for (int c = 0; c < 3; c++) begin
      fa.i_wr = 1'b1; fa.i_data = 8'(8'h40 + c);
      tick();
    end
    fa.i_wr = 1'b0;
    n_tests++;
    if (fa.o_fill !== 6'd3 || fa.o_udf !== 1'b1) begin
      n_fail++; $display("FAIL clr_pre got fill=%0d udf=%b want 3 1", fa.o_fill, fa.o_udf);
    end
    fa.i_clr = 1'b1; fa.i_wr = 1'b1; fa.i_data = 8'h77;
    tick();
    fa.i_clr = 1'b0; fa.i_wr = 1'b0;
    n_tests++;
    if (fa.o_fill !== 6'd0 || fa.o_empty_n !== 1'b0 || fa.o_udf !== 1'b0 || fa.o_ovf !== 1'b0 ||
        fa.o_aempty !== 1'b1 || fa.o_dmp_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_sync got fill=%0d empty_n=%b udf=%b ovf=%b aempty=%b dv=%b want 0 0 0 0 1 0",
        fa.o_fill, fa.o_empty_n, fa.o_udf, fa.o_ovf, fa.o_aempty, fa.o_dmp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full();
    test_underflow();
    test_wrap_dump();
    test_regread();
    test_reset_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
